// File: rtl/vcve2_pkg.sv
// vcve2 shared types for the writeback stage.
//   wb_instr_e : kind of instruction entering writeback (ALU result, load, store)
//   wb_state_e : writeback stage state
package vcve2_pkg;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_LOAD  = 2'd1,
    WB_STORE = 2'd2
  } wb_instr_e;

  // State literals carry a WBS_ prefix so they do not collide with the
  // wb_instr_e literals in this package scope.
  typedef enum logic [1:0] {
    WBS_IDLE = 2'd0,
    WBS_ALU  = 2'd1,
    WBS_MEM  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/vcve2_wb_stage.sv
// vcve2 writeback stage.
// Holds one retiring instruction and writes the register file with either the
// held EX result (ALU) or the LSU load data (passed straight through in the
// response cycle). Lets EX move on while a load/store response is pending.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   en_wb_i, instr_type_wb_i   instruction leaving EX and its kind
//   rf_waddr_id_i, rf_we_id_i  destination register / write request
//   rf_wdata_ex_i, pc_id_i     EX result and PC of the incoming instruction
//   lsu_resp_valid_i, lsu_rdata_i, lsu_err_i  LSU response
//   ready_wb_o                 stage can accept en_wb_i this cycle
//   rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o  RF write port
//   rf_fwd_valid_o             write data/address valid for forwarding to ID
//   outstanding_mem_o          load/store waiting for its response
//   instr_done_wb_o, lsu_err_wb_o  retire / bus-error pulses
//   pc_wb_o                    PC of the held instruction
//   instret_o                  retired-instruction counter (wraps)
module vcve2_wb_stage
  import vcve2_pkg::*;
#(
  parameter int unsigned RetCntWidth = 64,
  parameter bit          FwdEn       = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_wb_i,
  input  logic [1:0]             instr_type_wb_i,
  input  logic [4:0]             rf_waddr_id_i,
  input  logic                   rf_we_id_i,
  input  logic [31:0]            rf_wdata_ex_i,
  input  logic [31:0]            pc_id_i,
  input  logic                   lsu_resp_valid_i,
  input  logic [31:0]            lsu_rdata_i,
  input  logic                   lsu_err_i,
  output logic                   ready_wb_o,
  output logic [4:0]             rf_waddr_wb_o,
  output logic [31:0]            rf_wdata_wb_o,
  output logic                   rf_we_wb_o,
  output logic                   rf_fwd_valid_o,
  output logic                   outstanding_mem_o,
  output logic                   instr_done_wb_o,
  output logic [31:0]            pc_wb_o,
  output logic                   lsu_err_wb_o,
  output logic [RetCntWidth-1:0] instret_o
);

  wb_state_e              state_q, state_d;
  wb_instr_e              type_q, type_d;
  logic [4:0]             waddr_q, waddr_d;
  logic                   we_q, we_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            pc_q, pc_d;
  logic [RetCntWidth-1:0] instret_q, instret_d;

  wb_instr_e in_type;
  logic      in_we_eff;
  logic      in_alu, in_mem, mem_done, instr_done, capture;

  assign in_type   = wb_instr_e'(instr_type_wb_i);
  assign in_we_eff = rf_we_id_i & (|rf_waddr_id_i) & (in_type != WB_STORE);

  assign in_alu     = (state_q == WBS_ALU);
  assign in_mem     = (state_q == WBS_MEM);
  assign mem_done   = in_mem & lsu_resp_valid_i;
  assign instr_done = in_alu | mem_done;
  assign ready_wb_o = (state_q == WBS_IDLE) | instr_done;
  assign capture    = en_wb_i & ready_wb_o;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    waddr_d   = waddr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    instret_d = instret_q + RetCntWidth'(instr_done);
    if (instr_done) begin
      state_d = WBS_IDLE;
    end
    // Capture overrides the completion transition so a new instruction can
    // enter in the same cycle the current one retires.
    if (capture) begin
      type_d  = in_type;
      waddr_d = rf_waddr_id_i;
      we_d    = in_we_eff;
      wdata_d = rf_wdata_ex_i;
      pc_d    = pc_id_i;
      state_d = ((in_type == WB_LOAD) || (in_type == WB_STORE)) ? WBS_MEM : WBS_ALU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= WBS_IDLE;
      type_q    <= WB_ALU;
      waddr_q   <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      pc_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      waddr_q   <= waddr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // we_q already excludes stores and x0; errored responses never write.
  assign rf_we_wb_o        = (in_alu & we_q) |
                             (mem_done & ~lsu_err_i & (type_q == WB_LOAD) & we_q);
  assign rf_wdata_wb_o     = in_mem ? lsu_rdata_i : wdata_q;
  assign rf_waddr_wb_o     = waddr_q;
  assign rf_fwd_valid_o    = FwdEn & rf_we_wb_o;
  assign outstanding_mem_o = in_mem;
  assign instr_done_wb_o   = instr_done;
  assign lsu_err_wb_o      = mem_done & lsu_err_i;
  assign pc_wb_o           = pc_q;
  assign instret_o         = instret_q;

`ifndef SYNTHESIS
  // Upstream must only offer an instruction when the stage is ready.
  a_en_when_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    en_wb_i |-> ready_wb_o);
  // A response outside WBS_MEM (e.g. stale after reset) has no effect.
  a_stray_resp_ignored: assert property (@(posedge clk_i) disable iff (rst_i)
    (lsu_resp_valid_i && !in_mem) |-> (!instr_done_wb_o && !rf_we_wb_o && !lsu_err_wb_o));
`endif

endmodule

// File: doc/vcve2_wb_stage.md
Name: vcve2_wb_stage

Overview:
Writeback stage directly downstream of the vcve2 EX block and LSU. Holds one retiring instruction and writes the register file with either the EX result or the LSU load data. Produces retire pulses, forwarding data for ID, and back-pressure. Decouples the EX/LSU result timing from the RF write port, so EX can accept a new instruction while a load response is pending.

Parameters:
RetCntWidth, 64, width of the internal retired-instruction counter.
FwdEn, 1, 1 drives the forwarding outputs; 0 ties them to zero.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
en_wb_i  in  1  instruction leaving EX this cycle (ex_valid and ID handshake)
instr_type_wb_i  in  2  wb_instr_e: WB_ALU, WB_LOAD, WB_STORE
rf_waddr_id_i  in  5  destination register
rf_we_id_i  in  1  instruction writes RF
rf_wdata_ex_i  in  32  EX result
pc_id_i  in  32  PC of incoming instruction
lsu_resp_valid_i  in  1  LSU response for the outstanding load/store
lsu_rdata_i  in  32  formatted load data
lsu_err_i  in  1  bus error on the response
ready_wb_o  out  1  stage can accept en_wb_i this cycle
rf_waddr_wb_o  out  5  RF write address
rf_wdata_wb_o  out  32  RF write data
rf_we_wb_o  out  1  RF write enable
rf_fwd_valid_o  out  1  rf_wdata_wb_o and rf_waddr_wb_o are valid for forwarding
outstanding_mem_o  out  1  load/store awaiting response
instr_done_wb_o  out  1  instruction retires this cycle (1-cycle pulse)
pc_wb_o  out  32  PC of the held instruction
lsu_err_wb_o  out  1  retiring load/store completed with an error (1-cycle pulse)
instret_o  out  RetCntWidth  retired-instruction count

Behaviour:
- State register wb_state_e: WB_IDLE, WB_ALU, WB_MEM. After reset: WB_IDLE. After reset all outputs are 0; ready_wb_o is 1.
- Capture: on en_wb_i & ready_wb_o, register type, waddr, effective we, EX data, and pc. Next state is WB_ALU for WB_ALU and WB_MEM for load/store.
- Effective we = rf_we_id_i & (waddr != 0) & (type != WB_STORE).
- WB_ALU: rf_we_wb_o = effective we, rf_wdata_wb_o = held EX data, instr_done_wb_o = 1. The state is left in this cycle. Latency is exactly 1 cycle after capture.
- WB_MEM: outstanding_mem_o = 1. The stage waits for lsu_resp_valid_i.
  - Response with no error: instr_done_wb_o = 1. For a load, rf_we_wb_o = effective we and rf_wdata_wb_o = lsu_rdata_i (combinational pass-through).
  - Response with error: instr_done_wb_o = 1, lsu_err_wb_o = 1, no RF write.
  - The number of cycles spent waiting is unbounded.
- ready_wb_o = (state == WB_IDLE) | instr_done_wb_o. This allows back-to-back capture in the same cycle as completion, which gives 1 instruction per cycle throughput for the ALU stream. The next state on simultaneous completion and capture is the state of the new instruction.
- en_wb_i while ready_wb_o = 0 is a protocol violation. The input is ignored and an SVA is added.
- lsu_resp_valid_i outside WB_MEM is ignored and an SVA is added.
- Forwarding: rf_fwd_valid_o = FwdEn & rf_we_wb_o. The data is the same as the RF write data, with no extra latency.
- rf_waddr_wb_o and pc_wb_o are driven from the held registers in every state. Their value is don't-care in WB_IDLE but still driven, with no X.
- instret_o increments by 1 on each instr_done_wb_o and wraps modulo 2^RetCntWidth.
- Reset mid-operation (rst_i in WB_MEM): return to WB_IDLE and clear instret_o. Any later stale LSU response is ignored under the rule above.
- Held registers load only on capture, which keeps toggling low.

Decomposition:
- vcve2_pkg gains the following typedefs:
  - wb_instr_e: 2-bit enum, WB_ALU=0, WB_LOAD=1, WB_STORE=2.
  - wb_state_e: WB_IDLE, WB_ALU, WB_MEM.
- No sub-module. The retire counter is a plain always_ff inside the block.

Test Plan:
1. Reset, then idle: ready_wb_o=1, rf_we_wb_o=0, instret_o=0.
2. ALU stream: en_wb_i on 3 consecutive cycles, waddr 5/6/7, data 0x11/0x22/0x33 -> RF writes the same values on the 3 following cycles, ready_wb_o stays 1, instret_o=3.
3. Load to x9 with response 4 cycles later, rdata 0xDEADBEEF:
   - ready_wb_o=0 and outstanding_mem_o=1 for 4 cycles.
   - Then the x9 write of 0xDEADBEEF, with rf_fwd_valid_o=1 in the same cycle.
4. Store with response and lsu_err_i=1 -> lsu_err_wb_o pulse, no RF write, instret +1. A new ALU instruction offered in the response cycle is captured and written on the next cycle.
5. ALU write to x0 with data 0xFFFFFFFF -> rf_we_wb_o=0, instr_done_wb_o=1.
6. rst_i asserted while in WB_MEM, then lsu_resp_valid_i pulse -> state WB_IDLE, no RF write, instret_o=0.
